uart8_rx_fifo: RTL and testbench



---
 rtl/uart8_rx_fifo.sv | 120 ++++++++++++
 tb/tb_uart8_rx_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart8_rx_fifo.sv
// uart8_rx_fifo: receive-side byte buffer downstream of the 8-bit UART receiver.
// Converts the receiver's level-style done/data into one push per byte and
// presents the buffered bytes on a first-word-fall-through valid/ready port.
// Optional build macro: UART8_RX_FIFO_STATS_EN enables the rx_err rising-edge
// counter on err_count; without it err_count is tied to zero.
module uart8_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_done,
  input  logic                  rx_err,
  input  logic [7:0]            rx_data,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_ovf,
  output logic [7:0]            err_count
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned DW    = 8;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_nx;
  logic [CW-1:0] count_nx;
  logic          done_q;
  logic          push_req;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          bypass;

  // Push/pop decisions and next occupancy; bypass means the byte being
  // written this cycle becomes the head of the FIFO.
  always_comb begin
    push_req  = rx_done & ~done_q;
    full      = (level == CW'(DEPTH));
    pop       = rd_valid & rd_ready;
    push_ok   = push_req & (~full | pop);
    drop      = push_req & full & ~pop;
    rd_ptr_nx = pop ? (rd_ptr + AW'(1)) : rd_ptr;
    count_nx  = level;
    if (push_ok && !pop) begin
      count_nx = level + CW'(1);
    end else if (pop && !push_ok) begin
      count_nx = level - CW'(1);
    end
    bypass    = push_ok & (level == CW'(pop));
  end

  // Storage array write; pointers are reset elsewhere so contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Edge detect, pointers, occupancy, registered head byte and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b1;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      overflow <= 1'b0;
    end else begin
      done_q   <= rx_done;
      rd_ptr   <= rd_ptr_nx;
      level    <= count_nx;
      rd_valid <= (count_nx != '0);
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (bypass) begin
        rd_data <= rx_data;
      end else if (count_nx != '0) begin
        rd_data <= mem[rd_ptr_nx];
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART8_RX_FIFO_STATS_EN
  logic err_q;

  // Count rx_err rising edges, saturating at 8'hFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b1;
      err_count <= 8'h00;
    end else begin
      err_q <= rx_err;
      if (rx_err && !err_q && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`else
  logic unused_rx_err;

  // Statistics disabled: the error input has no effect.
  assign unused_rx_err = rx_err;
  assign err_count     = 8'h00;
`endif

endmodule

// File: tb/tb_uart8_rx_fifo.sv
// Directed self-checking bench for uart8_rx_fifo (DEPTH_LOG2 = 2, depth 4).
module tb_uart8_rx_fifo;

  localparam int unsigned DL2 = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           rx_done;
  logic           rx_err;
  logic [7:0]     rx_data;
  logic [7:0]     rd_data;
  logic           rd_valid;
  logic           rd_ready;
  logic [DL2:0]   level;
  logic           overflow;
  logic           clr_ovf;
  logic [7:0]     err_count;

  int n_cmp = 0;
  int n_err = 0;

  uart8_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rx_data   (rx_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One done pulse of len cycles followed by gap low cycles; consumer idle.
  task automatic pulse(input logic [7:0] d, input int len, input int gap);
    rx_data = d;
    rx_done = 1'b1;
    repeat (len) tick();
    rx_done = 1'b0;
    repeat (gap) tick();
  endtask

  // Pop one entry after checking it is the expected head byte.
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  logic [7:0] bvals [3];
  int         blens [3];

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    rd_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    rst = 1'b0;
    tick();

    // Long done hold produces a single push with one-cycle latency.
    rx_data = 8'hA5; rx_done = 1'b1;
    tick();
    chk("a5_valid", 32'(rd_valid), 32'd1);
    chk("a5_data", 32'(rd_data), 32'hA5);
    chk("a5_level", 32'(level), 32'd1);
    repeat (15) tick();
    chk("a5_hold_level", 32'(level), 32'd1);
    rx_done = 1'b0;
    repeat (20) tick();
    chk("a5_idle_level", 32'(level), 32'd1);
    chk("a5_idle_data", 32'(rd_data), 32'hA5);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_drained", 32'(level), 32'd0);
    chk("a5_drained_valid", 32'(rd_valid), 32'd0);

    // Three pulses with a continuously ready consumer; second pulse cut short.
    bvals[0] = 8'h01; bvals[1] = 8'h02; bvals[2] = 8'h03;
    blens[0] = 16;    blens[1] = 3;     blens[2] = 16;
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = bvals[i]; rx_done = 1'b1;
      tick();
      chk("stream_valid", 32'(rd_valid), 32'd1);
      chk("stream_data", 32'(rd_data), 32'(bvals[i]));
      chk("stream_level", 32'(level), 32'd1);
      tick();
      chk("stream_popped", 32'(rd_valid), 32'd0);
      repeat (blens[i] - 2) tick();
      rx_done = 1'b0;
      repeat (3) tick();
      chk("stream_gap_level", 32'(level), 32'd0);
    end
    rd_ready = 1'b0;

    // Overflow: five pushes into a depth-4 FIFO, the last one is dropped.
    for (int i = 0; i < 5; i++) pulse(8'(8'h10 + i), 2, 2);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_chk("ovf_read", 8'(8'h10 + i));
    chk("ovf_empty", 32'(level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO: push and pop in the same cycle keeps level and no overflow.
    for (int i = 0; i < 4; i++) pulse(8'(8'h20 + i), 2, 2);
    chk("full_level", 32'(level), 32'd4);
    rx_data = 8'hEE; rx_done = 1'b1; rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("full_pp_level", 32'(level), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_head", 32'(rd_data), 32'h21);
    repeat (4) tick();
    rx_done = 1'b0;
    tick();
    pop_chk("full_read", 8'h21);
    pop_chk("full_read", 8'h22);
    pop_chk("full_read", 8'h23);
    pop_chk("full_read_ee", 8'hEE);
    chk("full_drained", 32'(level), 32'd0);

    // Reset while done is high discards data and ignores the held done.
    pulse(8'h55, 2, 2);
    rx_data = 8'h66; rx_done = 1'b1;
    tick();
    chk("mid_level", 32'(level), 32'd2);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_data", 32'(rd_data), 32'h00);
    rst = 1'b0;
    repeat (5) tick();
    chk("held_done_level", 32'(level), 32'd0);
    chk("held_done_valid", 32'(rd_valid), 32'd0);
    rx_done = 1'b0;
    tick();
    rx_data = 8'h77; rx_done = 1'b1;
    tick();
    chk("after_rst_level", 32'(level), 32'd1);
    chk("after_rst_data", 32'(rd_data), 32'h77);
    rx_done = 1'b0;
    pop_chk("after_rst_pop", 8'h77);

`ifdef UART8_RX_FIFO_STATS_EN
    // Persistent error level counts once; counter saturates.
    rx_err = 1'b1;
    repeat (40) tick();
    chk("err_one", 32'(err_count), 32'd1);
    rx_err = 1'b0;
    tick();
    rx_err = 1'b1;
    tick();
    chk("err_two", 32'(err_count), 32'd2);
    for (int i = 0; i < 300; i++) begin
      rx_err = 1'b0;
      tick();
      rx_err = 1'b1;
      tick();
    end
    chk("err_sat", 32'(err_count), 32'hFF);
    chk("err_no_push", 32'(level), 32'd0);
`else
    // Statistics absent: error edges never move the counter.
    for (int i = 0; i < 5; i++) begin
      rx_err = 1'b1;
      repeat (3) tick();
      chk("err_tied_hi", 32'(err_count), 32'd0);
      rx_err = 1'b0;
      tick();
      chk("err_tied_lo", 32'(err_count), 32'd0);
    end
    chk("err_no_push", 32'(level), 32'd0);
`endif
    rx_err = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
